// File: rtl/rst_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_e : sequencer FSM states (hold all, staggered release, running)
//   cnt_width() : width of the cycle counter so that it can hold the larger
//                 of the assert hold and the stagger gap without wrapping.
package rst_pkg;

  typedef enum logic [1:0] {
    StAssert,
    StRelease,
    StRun
  } seq_state_e;

  function automatic int unsigned cnt_width(input int unsigned assert_cycles,
                                            input int unsigned stagger_cycles);
    int unsigned m;
    m = (assert_cycles > stagger_cycles) ? assert_cycles : stagger_cycles;
    // Keep at least one bit so the counter is never zero-width.
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds N_CH reset channels asserted for ASSERT_CYCLES after
// the last master reset or software request, then releases them one by one,
// STAGGER_CYCLES apart, channel 0 first. done rises with the last release.
//
// Ports
//   clk     : single clock, rising edge
//   rst     : synchronous active-high master reset (highest priority)
//   req     : software reset request, level-sampled every edge
//   rst_out : per-channel reset, polarity set by ACTIVE_HIGH_MASK (1 = active-high)
//   done    : high once every channel has been released
module rst_sequencer
  import rst_pkg::*;
#(
  parameter int unsigned     N_CH             = 4,
  parameter int unsigned     ASSERT_CYCLES    = 16,
  parameter int unsigned     STAGGER_CYCLES   = 4,
  parameter logic [N_CH-1:0] ACTIVE_HIGH_MASK = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  output logic [N_CH-1:0] rst_out,
  output logic            done
);

  if ((N_CH < 1) || (N_CH > 32)) begin : g_bad_n_ch
    $error("rst_sequencer: N_CH must be in 1..32");
  end
  if (ASSERT_CYCLES < 1) begin : g_bad_assert
    $error("rst_sequencer: ASSERT_CYCLES must be >= 1");
  end

  localparam int unsigned CntW = cnt_width(ASSERT_CYCLES, STAGGER_CYCLES);
  localparam int unsigned IdxW = $clog2(N_CH) + 1;

  // Counter value seen on the edge just before a release is due.
  localparam logic [CntW-1:0] AssertLast  =
    CntW'((ASSERT_CYCLES == 0) ? 0 : ASSERT_CYCLES - 1);
  localparam logic [CntW-1:0] StaggerLast =
    CntW'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(N_CH - 1);
  localparam logic [IdxW-1:0] IdxEnd      = IdxW'(N_CH);
  // Every channel leaves reset on the same edge; RELEASE is skipped.
  localparam bit              ReleaseAll  = (STAGGER_CYCLES == 0) || (N_CH == 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [N_CH-1:0] a_q, a_d;
  logic [N_CH-1:0] out_q, out_d;
  logic            done_q, done_d;

  logic            restart;
  logic            step;  // a release happens on this edge

  assign restart = rst | req;

  // State register; outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= '1;
      out_q   <= ACTIVE_HIGH_MASK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next state, counter and channel index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    step    = 1'b0;
    if (restart) begin
      state_d = StAssert;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        StAssert: begin
          if (cnt_q == AssertLast) begin
            step  = 1'b1;
            cnt_d = '0;
            if (ReleaseAll) begin
              state_d = StRun;
              idx_d   = IdxEnd;
            end else begin
              state_d = StRelease;
              idx_d   = IdxW'(1);
            end
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == StaggerLast) begin
            step  = 1'b1;
            cnt_d = '0;
            idx_d = (idx_q == IdxEnd) ? idx_q : idx_q + 1'b1;
            if (idx_q == IdxLast) begin
              state_d = StRun;
            end
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          end
        end
        StRun: begin
        end
        default: begin
          state_d = StAssert;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Assert vector, polarity mapping and done.
  always_comb begin
    a_d    = a_q;
    done_d = done_q;
    if (restart) begin
      a_d    = '1;
      done_d = 1'b0;
    end else if (step) begin
      if ((state_q == StAssert) && ReleaseAll) begin
        a_d    = '0;
        done_d = 1'b1;
      end else begin
        // idx_q names the channel whose release is due on this edge.
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (IdxW'(i) == idx_q) begin
            a_d[i] = 1'b0;
          end
        end
        done_d = (state_q == StRelease) && (idx_q == IdxLast);
      end
    end
    // Active-high channels follow a; active-low channels carry its inverse.
    out_d = a_d ^ ~ACTIVE_HIGH_MASK;
  end

  assign rst_out = out_q;
  assign done    = done_q;

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of reset output channels, legal range 1..32.
REQ-002 SHALL have parameter ASSERT_CYCLES, default 16: minimum hold of all channels after the last reset/request edge, legal range >=1.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 4: gap between consecutive channel releases; legal range >=0, where 0 means simultaneous release.
REQ-004 SHALL have parameter ACTIVE_HIGH_MASK, default all ones, N_CH bits: bit i=1 makes channel i active-high, bit i=0 makes it active-low.
REQ-005 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: master reset, synchronous, active-high.
REQ-007 Port req, input, 1: software reset request, level-sampled on each clk edge.
REQ-008 Port rst_out, output, N_CH: per-channel reset, with polarity per ACTIVE_HIGH_MASK.
REQ-009 Port done, output, 1: high when all channels are released.

Function
REQ-010 SHALL implement the FSM states ASSERT, RELEASE and RUN.
REQ-011 Internal assert vector a[i]: rst_out[i] = ACTIVE_HIGH_MASK[i] ? a[i] : ~a[i].
REQ-012 rst_out and done SHALL be driven directly from flops, with no combinational path from any input.
REQ-013 Define t0 as the last clk edge at which rst or req was sampled high; at t0 the state becomes ASSERT, all a[i]=1, done=0 and the counter is cleared.
REQ-014 Channel i SHALL deassert at edge t0 + ASSERT_CYCLES + i*STAGGER_CYCLES, in index order 0 first.
REQ-015 The state SHALL be ASSERT until edge t0+ASSERT_CYCLES, then RELEASE until the last channel is released, then RUN.
REQ-016 done SHALL rise on the same edge as channel N_CH-1 deasserts and hold high in RUN.
REQ-017 With STAGGER_CYCLES=0, all channels SHALL release on edge t0+ASSERT_CYCLES and the FSM SHALL go straight from ASSERT to RUN.
REQ-018 With N_CH=1, release and done SHALL coincide at t0+ASSERT_CYCLES.
REQ-019 req sampled high in any state (RUN, ASSERT or RELEASE) SHALL re-base t0: on that edge all channels reassert and done clears.
REQ-020 req held high SHALL keep all channels asserted; the sequence starts counting from the last high sample.
REQ-021 rst and req high together SHALL behave identically to rst alone.
REQ-022 The counter SHALL be $clog2(max(ASSERT_CYCLES,STAGGER_CYCLES)+1) bits wide and SHALL NOT wrap.
REQ-023 The channel index SHALL be $clog2(N_CH)+1 bits wide, saturating at N_CH.
REQ-024 An already released channel SHALL NOT reassert except on rst or req.
REQ-025 Illegal parameters (N_CH outside 1..32, ASSERT_CYCLES<1) SHALL be flagged by an elaboration-time $error.

Reset
REQ-026 While rst is sampled high: state=ASSERT, counter=0, channel index=0, a=all ones, and rst_out=ACTIVE_HIGH_MASK.
REQ-027 While rst is sampled high, done SHALL be 0.
REQ-028 rst SHALL take priority over every other input.
REQ-029 rst asserted mid-sequence SHALL abort the sequence and re-base t0.
REQ-030 The sequencer SHALL use no asynchronous reset and no initial-value dependence.

Structure
REQ-031 Package rst_pkg SHALL hold the state enum typedef (ASSERT, RELEASE, RUN) and the counter-width helper function.
REQ-032 No sub-module is warranted: FSM, counter, index and polarity mapping live in rst_sequencer.
REQ-033 RTL size target: 120-250 lines.

Verification (N_CH=3, ASSERT_CYCLES=4, STAGGER_CYCLES=2, ACTIVE_HIGH_MASK=3'b101 unless stated)
REQ-034 rst high 3 cycles, low from edge t0 -> rst_out=101 through t0+3; ch0 releases at t0+4 (100); ch1 at t0+6 (110); ch2 at t0+8 (010), with done=1 at t0+8.
REQ-035 In RUN, a 1-cycle req pulse at edge R -> rst_out=101 and done=0 at R; releases follow at R+4, R+6 and R+8.
REQ-036 req at t0+5 (ch0 released, ch1 not yet) -> rst_out=101 at t0+5; releases re-based to t0+9, t0+11 and t0+13.
REQ-037 rst high for 1 cycle at t0+7 -> identical re-base (releases at t0+11, t0+13, t0+15); done stays 0 until t0+15.
REQ-038 req held high 10 cycles (last high edge H) -> rst_out=101 throughout; releases at H+4, H+6 and H+8.
REQ-039 STAGGER_CYCLES=0 and N_CH=1 instances -> all channels and done release at t0+4; no RELEASE state is entered.
